uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive stage of the user-project UART. It sits directly downstream of the chip pin `mprj_io[5]`, which the bench UART transmitter drives. It deserialises 8N1 frames, checks framing, and buffers received bytes. The bytes are presented to the user-project firmware interface through a valid/ready handshake and a level interrupt.

## Interface
- `CLKS_PER_BIT`, default 347: clock cycles per bit (40 MHz / 115200 baud); legal range 8 to 65535.
- `FIFO_DEPTH`, default 8: receive buffer entries; must be a power of two, 2 to 64; used only with `UART_RX_FIFO_EN`.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx_i`  in  1: raw serial line; idle high; asynchronous to `clk`.
- `rx_data_o`  out  8: head byte; valid only while `rx_valid_o` is high.
- `rx_valid_o`  out  1: a byte is available.
- `rx_ready_i`  in  1: consumer pop; a byte is popped when `rx_valid_o` and `rx_ready_i` are both high.
- `frame_err_o`  out  1: one-cycle pulse when the stop bit samples low.
- `overrun_o`  out  1: one-cycle pulse when a good byte is dropped because the buffer is full.
- `rx_count_o`  out  7: number of bytes currently buffered.
- `irq_o`  out  1: level output, equal to `rx_valid_o`.

## Operation
- Input synchroniser: two flops on `rx_i`, both reset to 1. All later logic uses only the synchronised bit `rxs`.
- FSM states are IDLE, START, DATA, STOP and WAIT_HI. A bit counter `cnt` has width clog2(`CLKS_PER_BIT`). A bit index `idx` is 3 bits.
- IDLE: when `rxs` is 0, clear `cnt` and go to START.
- START: when `cnt` equals `CLKS_PER_BIT`/2 − 1, sample `rxs`.
  - If it is 0, clear `cnt` and `idx` and go to DATA.
  - If it is 1, treat it as a glitch and return to IDLE with no output.
- DATA: every `CLKS_PER_BIT` cycles, shift `rxs` into the shift register, LSB first. After `idx` reaches 7, go to STOP.
- STOP: `CLKS_PER_BIT` cycles after the last data sample, sample `rxs`.
  - If it is 1, push the byte and go to IDLE.
  - If it is 0, pulse `frame_err_o`, discard the byte and go to WAIT_HI.
- WAIT_HI: stay until `rxs` is 1, then go to IDLE. A break condition therefore produces exactly one `frame_err_o`.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted, with no overrun and no change in count.
  - Otherwise the new byte is dropped, `overrun_o` pulses, and the buffered contents are unchanged.
- Pop when empty: ignored.
- Output is first-word fall-through: `rx_data_o` shows the head entry combinationally from storage. `rx_data_o` holds its value while `rx_valid_o` is high and `rx_ready_i` is low.
- Reset mid-frame: the FSM goes to IDLE, the buffer empties, and the partial byte is lost. After reset the receiver re-arms only on a new falling edge seen after `rxs` has been high.

## Timing
- Reset values:
  - `rx_data_o` is 0x00.
  - `rx_valid_o`, `frame_err_o`, `overrun_o` and `irq_o` are 0.
  - `rx_count_o` is 0.
  - The FSM is in IDLE.
- Synchroniser latency is 2 cycles from the `rx_i` edge to `rxs`.
- Sample points are measured from the cycle in which IDLE sees `rxs` = 0:
  - start bit at `CLKS_PER_BIT`/2;
  - data bit n at `CLKS_PER_BIT`/2 + (n+1)·`CLKS_PER_BIT`;
  - stop bit at `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT`.
- After the stop-bit sample:
  - `rx_valid_o` and `rx_count_o` update in the next cycle;
  - `frame_err_o` and `overrun_o` pulse in the next cycle, for exactly 1 cycle.
- Pop takes effect on the clock edge. The next head byte appears the following cycle, with no bubble.
- Back-to-back frames are supported: IDLE can detect the next start bit 1 cycle after the stop sample.

## Configuration
- `UART_RX_FIFO_EN` defined:
  - circular buffer of `FIFO_DEPTH` entries, with read and write pointers one bit wider than the address;
  - `rx_count_o` ranges from 0 to `FIFO_DEPTH`.
- `UART_RX_FIFO_EN` undefined:
  - a single holding register, so the effective depth is 1 and `rx_count_o` is 0 or 1;
  - a second byte arriving before the first is popped causes an overrun;
  - `FIFO_DEPTH` is ignored.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, WAIT_HI);
  - `UART_DATA_W` = 8;
  - the default `CLKS_PER_BIT`.
- Sub-module `uart_rx_fifo` is the generic synchronous FIFO:
  - push/pop, `full`/`empty`, count, first-word fall-through;
  - it is instantiated only under `UART_RX_FIFO_EN`.
- The FSM, synchroniser and shift register stay in `uart_rx_core`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and, unless stated otherwise, `FIFO_DEPTH`=4.
- Send bytes 0x01 through 0x0A back-to-back with `rx_ready_i`=1:
  - 10 valid handshakes with data 0x01 to 0x0A in order;
  - no `frame_err_o`, no `overrun_o`.
- Send 0x0F, 0x3D, 0x1D, 0x24, 0xA5 with `rx_ready_i`=0:
  - `rx_count_o` reaches 4;
  - `overrun_o` pulses once, on 0xA5;
  - draining returns 0x0F, 0x3D, 0x1D, 0x24.
- Send frame 0x55 with the stop bit driven 0, then hold the line low for 3 bit times:
  - exactly one `frame_err_o` pulse;
  - `rx_count_o` stays 0;
  - a following 0x42 is received correctly.
- Drive a 4-cycle low glitch on an idle line:
  - no byte, no error;
  - the FSM is back in IDLE within 8 cycles.
- Assert `rst_n` low during bit 4 of a 0xC3 frame, release it, then send 0x7E:
  - outputs match their reset values during reset;
  - only 0x7E is received.
- Build without `UART_RX_FIFO_EN` and send 0x11 then 0x22 with `rx_ready_i`=0:
  - 0x11 is held;
  - `overrun_o` pulses on 0x22;
  - `rx_count_o` is 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Contents: uart_rx_state_t (receiver FSM states), UART_DATA_W (byte width),
//           UART_CLKS_PER_BIT (default bit period: 40 MHz / 115200 baud).
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 347;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: generic synchronous first-word-fall-through FIFO.
// Ports: clk, rst_n (async active-low), push_i/data_i (write side),
//        pop_i (read side), data_o (head entry, combinational from storage),
//        full_o, empty_o, count_o (entries held, 0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored.
module uart_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic         do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        count_o = wr_q - rd_q;
        empty_o = (count_o == '0);
        full_o  = (count_o == (AW+1)'(DEPTH));
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        data_o  = mem_q[rd_q[AW-1:0]];
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = data_i;
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with framing check and receive buffer.
// Ports: clk, rst_n (async active-low), rx_i (raw serial line, idle high),
//        rx_data_o/rx_valid_o/rx_ready_i (FWFT byte handshake),
//        frame_err_o (1-cycle pulse on low stop bit),
//        overrun_o (1-cycle pulse when a good byte is dropped),
//        rx_count_o (bytes buffered), irq_o (level, equals rx_valid_o).
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer;
// otherwise a single holding register is used and FIFO_DEPTH is ignored.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic [6:0]             rx_count_o,
    output logic                   irq_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_rx_state_t         state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rxs, push, pop, full;

    assign rxs = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], rx_i};
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            // Mid-start-bit check rejects short low glitches.
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[UART_DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d       = '0;
                    push        = rxs;
                    frame_err_d = !rxs;
                    state_d     = rxs ? IDLE : WAIT_HI;
                end
            end
            // Hold off until the line returns high so a break errors only once.
            WAIT_HI: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pop         = rx_valid_o && rx_ready_i;
    assign overrun_d   = push && full && !pop;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign irq_o       = rx_valid_o;

`ifdef UART_RX_FIFO_EN
    logic                        empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_rx_fifo #(
        .W     (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign rx_valid_o = !empty;
    assign rx_count_o = 7'(fifo_count);
`else
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   accept;

    // Single-entry buffer: a new byte fits only if empty or popped this cycle.
    always_comb begin
        accept  = push && (!valid_q || pop);
        valid_d = accept || (valid_q && !pop);
        data_d  = accept ? shift_q : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign full       = valid_q;
    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;
    assign rx_count_o = {6'b0, valid_q};
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core (CLKS_PER_BIT=16).
module tb_uart_rx_core;

    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int D4 = (DEPTH < 4) ? DEPTH : 4;
    localparam int D2 = (DEPTH < 2) ? DEPTH : 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic [6:0] rx_count_o;
    logic       irq_o;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int ferr0, ovr0;
    logic [7:0] rxq[$];

    uart_rx_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .rx_count_o  (rx_count_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            if (rx_valid_o && rx_ready_i) rxq.push_back(rx_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_cyc(CPB);
        end
        rx_i = stop_bit;
        wait_cyc(CPB);
    endtask

    task automatic snap();
        ferr0 = ferr_cnt;
        ovr0  = ovr_cnt;
        rxq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, rx_data_o, 8'h00);
        check({tag, "_valid"}, rx_valid_o, 1'b0);
        check({tag, "_ferr"}, frame_err_o, 1'b0);
        check({tag, "_ovr"}, overrun_o, 1'b0);
        check({tag, "_count"}, rx_count_o, 7'd0);
        check({tag, "_irq"}, irq_o, 1'b0);
    endtask

    initial begin
        logic [7:0] t2 [5];
        logic [7:0] c3;
        t2 = '{8'h0F, 8'h3D, 8'h1D, 8'h24, 8'hA5};
        c3 = 8'hC3;
        rst_n = 1'b0;
        rx_i = 1'b1;
        rx_ready_i = 1'b0;
        wait_cyc(3);
        check_reset_vals("rst");
        rst_n = 1'b1;
        wait_cyc(5);

        // Back-to-back 0x01..0x0A with consumer always ready.
        rx_ready_i = 1'b1;
        snap();
        for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b1);
        wait_cyc(CPB);
        check("b2b_n", rxq.size(), 10);
        for (int i = 0; i < 10; i++) check("b2b_data", rxq[i], i + 1);
        check("b2b_ferr", ferr_cnt - ferr0, 0);
        check("b2b_ovr", ovr_cnt - ovr0, 0);
        check("b2b_count", rx_count_o, 0);

        // Fill with consumer stalled, then overflow and drain.
        rx_ready_i = 1'b0;
        snap();
        for (int i = 0; i < 4; i++) send_byte(t2[i], 1'b1);
        wait_cyc(2);
        check("fill4_count", rx_count_o, D4);
        check("fill4_ovr", ovr_cnt - ovr0, 4 - D4);
        send_byte(t2[4], 1'b1);
        wait_cyc(2);
        check("fill5_count", rx_count_o, DEPTH);
        check("fill5_ovr", ovr_cnt - ovr0, 5 - DEPTH);
        check("fill5_head", rx_data_o, 8'h0F);
        check("fill5_valid", rx_valid_o, 1'b1);
        check("fill5_irq", irq_o, 1'b1);
        rx_ready_i = 1'b1;
        wait_cyc(DEPTH);
        check("drain_count", rx_count_o, 0);
        rx_ready_i = 1'b0;
        check("drain_n", rxq.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("drain_data", rxq[i], t2[i]);

        // Low stop bit followed by a break of 3 bit times.
        rx_ready_i = 1'b1;
        snap();
        send_byte(8'h55, 1'b0);
        wait_cyc(3 * CPB);
        rx_i = 1'b1;
        wait_cyc(CPB);
        check("break_ferr", ferr_cnt - ferr0, 1);
        check("break_count", rx_count_o, 0);
        check("break_n", rxq.size(), 0);
        send_byte(8'h42, 1'b1);
        wait_cyc(CPB);
        check("after_break_n", rxq.size(), 1);
        check("after_break_data", rxq[0], 8'h42);

        // Short low glitch on an idle line, then a real frame soon after.
        snap();
        rx_i = 1'b0;
        wait_cyc(4);
        rx_i = 1'b1;
        wait_cyc(20);
        check("glitch_n", rxq.size(), 0);
        check("glitch_ferr", ferr_cnt - ferr0, 0);
        check("glitch_count", rx_count_o, 0);
        rx_i = 1'b1;
        wait_cyc(8);
        send_byte(8'h5A, 1'b1);
        wait_cyc(CPB);
        check("post_glitch_n", rxq.size(), 1);
        check("post_glitch_data", rxq[0], 8'h5A);

        // Reset in the middle of bit 4 of 0xC3.
        snap();
        rx_i = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = c3[i];
            wait_cyc(CPB);
        end
        rx_i = c3[4];
        wait_cyc(CPB / 2);
        rst_n = 1'b0;
        wait_cyc(2);
        check_reset_vals("midrst");
        wait_cyc(CPB / 2 - 2);
        rx_i = c3[5];
        wait_cyc(CPB);
        rx_i = c3[6];
        wait_cyc(CPB / 2);
        rst_n = 1'b1;
        wait_cyc(CPB / 2 + 2 * CPB);
        send_byte(8'h7E, 1'b1);
        wait_cyc(CPB);
        check("midrst_n", rxq.size(), 1);
        check("midrst_data", rxq[0], 8'h7E);
        check("midrst_ferr", ferr_cnt - ferr0, 0);

        // Two bytes with consumer stalled.
        rx_ready_i = 1'b0;
        snap();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cyc(2);
        check("pair_head", rx_data_o, 8'h11);
        check("pair_ovr", ovr_cnt - ovr0, 2 - D2);
        check("pair_count", rx_count_o, D2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
